specdrum_i2s_tx: RTL and testbench



---
 rtl/specdrum_i2s_tx.sv | 122 ++++++++++++
 tb/tb_specdrum_i2s_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/specdrum_i2s_tx.sv
// ---------------------------------------------------------------------------
// specdrum_i2s_tx
//
// Converts the two 9-bit unsigned channel sums of the Specdrum/Covox/Soundrive
// DAC stage (0..510, midpoint 256) into signed 16-bit PCM and sends them as a
// Philips I2S stream. This block is the I2S master. Every output is a flop in
// the clk domain.
//
// Parameters:
//   BCLK_DIV      clk cycles per BCLK half-period (1..255).
//                 BCLK = clk/(2*BCLK_DIV), fs = clk/(64*BCLK_DIV).
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   mute          1 = the next latched stereo pair is zero
//   left_in       unsigned left sample
//   right_in      unsigned right sample
//   i2s_bclk      bit clock
//   i2s_lrck      word select (0 = left, 1 = right)
//   i2s_sdata     serial data, MSB first, one BCLK behind LRCK
//   sample_strobe one-clk pulse when a new stereo pair is latched
// ---------------------------------------------------------------------------
module specdrum_i2s_tx #(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mute,
  input  logic [8:0] left_in,
  input  logic [8:0] right_in,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_sdata,
  output logic       sample_strobe
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        bclk_q, bclk_d;
  logic        lrck_q, lrck_d;
  logic        sdata_q, sdata_d;
  logic        strobe_q, strobe_d;
  logic [31:0] shreg_q, shreg_d;
  logic [15:0] r_hold_q, r_hold_d;

  logic        tick;
  logic        fall_evt;
  logic [15:0] l16, r16;

  // Flipping the MSB of an offset-binary 9-bit value yields the two's
  // complement of (x - 256); the 7 zero LSBs scale it to full 16-bit range.
  function automatic logic [15:0] to_pcm(input logic [8:0] x, input logic m);
    return m ? 16'h0000 : {x ^ 9'h100, 7'b000_0000};
  endfunction

  assign l16      = to_pcm(left_in, mute);
  assign r16      = to_pcm(right_in, mute);
  assign tick     = (div_cnt_q == DIV_LAST);
  assign fall_evt = tick && bclk_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = tick ? ~bclk_q : bclk_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    strobe_d  = 1'b0;
    shreg_d   = shreg_q;
    r_hold_d  = r_hold_q;

    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd31) begin
        // Slot 0 still owes the previous right word its LSB, hence r_hold.
        shreg_d  = {r_hold_q[0], l16, r16[15:1]};
        r_hold_d = r16;
        strobe_d = 1'b1;
      end else begin
        shreg_d = shreg_q << 1;
      end
      // Data and word select both follow the new slot, so they change on the
      // same clk edge that drops BCLK.
      sdata_d = shreg_d[31];
      lrck_d  = bit_cnt_d[4];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 5'd31;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b1;
      sdata_q   <= 1'b0;
      strobe_q  <= 1'b0;
      shreg_q   <= 32'd0;
      r_hold_q  <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      strobe_q  <= strobe_d;
      shreg_q   <= shreg_d;
      r_hold_q  <= r_hold_d;
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_specdrum_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_specdrum_i2s_tx
//
// Directed bench for specdrum_i2s_tx. Two instances share clk: dut2 with
// BCLK_DIV=2 for the main scenarios and dut1 with BCLK_DIV=1 for the
// fastest divider. Outputs are sampled on the falling clk edge; a BCLK fall
// is seen as i2s_bclk 1 -> 0 between two consecutive samples.
//
// Expected PCM words (x ^ 0x100, shifted left 7):
//   0x1FE -> 0x7F00   0x000 -> 0x8000   0x100 -> 0x0000
//   0x0AB -> 0xD580   0x17F -> 0x3F80   mute  -> 0x0000
// ---------------------------------------------------------------------------
module tb_specdrum_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2_n, mute2;
  logic [8:0] left2, right2;
  logic       bclk2, lrck2, sdata2, stb2;

  logic       rst1_n, mute1;
  logic [8:0] left1, right1;
  logic       bclk1, lrck1, sdata1, stb1;

  int checks = 0;
  int errors = 0;

  specdrum_i2s_tx #(.BCLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mute(mute2),
    .left_in(left2), .right_in(right2),
    .i2s_bclk(bclk2), .i2s_lrck(lrck2), .i2s_sdata(sdata2),
    .sample_strobe(stb2)
  );

  specdrum_i2s_tx #(.BCLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .mute(mute1),
    .left_in(left1), .right_in(right1),
    .i2s_bclk(bclk1), .i2s_lrck(lrck1), .i2s_sdata(sdata1),
    .sample_strobe(stb1)
  );

  // Advance falling clk edges until the selected DUT's BCLK falls. Reports
  // edges consumed and how many of them saw sample_strobe high.
  task automatic wait_fall(input bit d1, input string tag,
                           output int waited, output int stb_hits);
    bit prev, cur, found;
    prev     = d1 ? bclk1 : bclk2;
    found    = 1'b0;
    waited   = 0;
    stb_hits = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      waited++;
      cur = d1 ? bclk1 : bclk2;
      if (d1 ? stb1 : stb2) stb_hits++;
      if (prev && !cur) found = 1'b1;
      prev = cur;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s bclk_fall_timeout: no fall within 600 clk", tag);
    end
  endtask

  // Starting right after a slot-0 fall, follow 32 falls up to the next slot
  // 0. New inputs are applied at slot 8, so they must appear only in the
  // following frame.
  task automatic run_frame(input bit d1, input string tag,
                           input logic [15:0] exp_l, input logic [15:0] exp_r,
                           input int exp_len,
                           input logic [8:0] nl, input logic [8:0] nr,
                           input logic nm);
    logic [15:0] lw, rw;
    logic [31:0] lr_pat, stb_pat;
    int waited, hits, total, stb_total, slot;
    logic sd, lr, sb;
    lw = '0; rw = '0; lr_pat = '0; stb_pat = '0; total = 0; stb_total = 0;
    for (int k = 1; k <= 32; k++) begin
      wait_fall(d1, tag, waited, hits);
      total     += waited;
      stb_total += hits;
      sd   = d1 ? sdata1 : sdata2;
      lr   = d1 ? lrck1  : lrck2;
      sb   = d1 ? stb1   : stb2;
      slot = k % 32;
      lr_pat[slot]  = lr;
      stb_pat[slot] = sb;
      if (k <= 16)      lw[16-k] = sd;
      else if (k <= 31) rw[32-k] = sd;
      else              rw[0]    = sd;
      if (k == 8) begin
        if (d1) begin left1 = nl; right1 = nr; mute1 = nm; end
        else    begin left2 = nl; right2 = nr; mute2 = nm; end
      end
    end
    checks++;
    if (lw !== exp_l) begin
      errors++; $display("FAIL %s left_word: got %h expected %h", tag, lw, exp_l);
    end
    checks++;
    if (rw !== exp_r) begin
      errors++; $display("FAIL %s right_word: got %h expected %h", tag, rw, exp_r);
    end
    checks++;
    if (lr_pat !== 32'hFFFF_0000) begin
      errors++; $display("FAIL %s lrck_slots: got %h expected ffff0000", tag, lr_pat);
    end
    checks++;
    if (stb_pat !== 32'h0000_0001 || stb_total !== 1) begin
      errors++;
      $display("FAIL %s strobe: slots %h pulses %0d expected 00000001 and 1",
               tag, stb_pat, stb_total);
    end
    checks++;
    if (total !== exp_len) begin
      errors++; $display("FAIL %s frame_len: got %0d clk expected %0d", tag, total, exp_len);
    end
  endtask

  // After reset release the first fall comes 4 clk later (BCLK_DIV=2) and
  // performs the load of slot 0.
  task automatic check_first_load(input string tag);
    int waited, hits;
    wait_fall(1'b0, tag, waited, hits);
    checks++;
    if (waited !== 4) begin
      errors++; $display("FAIL %s first_fall: got clk %0d expected 4", tag, waited);
    end
    checks++;
    if (stb2 !== 1'b1 || hits !== 1) begin
      errors++; $display("FAIL %s first_strobe: got %b/%0d expected 1/1", tag, stb2, hits);
    end
    checks++;
    if (lrck2 !== 1'b0 || sdata2 !== 1'b0) begin
      errors++;
      $display("FAIL %s slot0: lrck %b sdata %b expected 0 0", tag, lrck2, sdata2);
    end
  endtask

  task automatic test_reset();
    rst2_n = 1'b0; mute2 = 1'b0; left2 = 9'h1FE; right2 = 9'h000;
    rst1_n = 1'b0; mute1 = 1'b0; left1 = 9'h0AB; right1 = 9'h17F;
    repeat (4) @(negedge clk);
    checks++;
    if ({bclk2, lrck2, sdata2, stb2} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_values: bclk/lrck/sdata/strobe %b expected 0100",
               {bclk2, lrck2, sdata2, stb2});
    end
    rst2_n = 1'b1;
    check_first_load("reset_release");
  endtask

  task automatic test_frame_data();
    // Frame latched 0x1FE/0x000; left changes to 0x000 mid-frame.
    run_frame(1'b0, "frame_7f00", 16'h7F00, 16'h8000, 128, 9'h000, 9'h000, 1'b0);
  endtask

  task automatic test_input_change();
    run_frame(1'b0, "frame_8000", 16'h8000, 16'h8000, 128, 9'h100, 9'h100, 1'b0);
  endtask

  task automatic test_midpoint();
    run_frame(1'b0, "midpoint", 16'h0000, 16'h0000, 128, 9'h1FE, 9'h1FE, 1'b1);
  endtask

  task automatic test_mute();
    run_frame(1'b0, "mute", 16'h0000, 16'h0000, 128, 9'h0AB, 9'h1FE, 1'b0);
  endtask

  task automatic test_pattern();
    run_frame(1'b0, "pattern", 16'hD580, 16'h7F00, 128, 9'h0AB, 9'h1FE, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int waited, hits;
    for (int k = 1; k <= 20; k++) wait_fall(1'b0, "mid_reset", waited, hits);
    repeat (2) @(negedge clk);
    // Slot 20 carries bit 12 of 0x7F00 and BCLK is high here, so every
    // output differs from its reset value where it can.
    checks++;
    if ({bclk2, lrck2, sdata2} !== 3'b111) begin
      errors++;
      $display("FAIL mid_reset_pre: bclk/lrck/sdata %b expected 111", {bclk2, lrck2, sdata2});
    end
    rst2_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bclk2, lrck2, sdata2, stb2} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset_values: bclk/lrck/sdata/strobe %b expected 0100",
               {bclk2, lrck2, sdata2, stb2});
    end
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    check_first_load("mid_reset_release");
    run_frame(1'b0, "mid_reset_frame", 16'hD580, 16'h7F00, 128, 9'h0AB, 9'h1FE, 1'b0);
  endtask

  task automatic test_div1();
    int waited, hits;
    rst1_n = 1'b1;
    wait_fall(1'b1, "div1", waited, hits);
    checks++;
    if (waited !== 2 || stb1 !== 1'b1 || lrck1 !== 1'b0) begin
      errors++;
      $display("FAIL div1_first_fall: clk %0d strobe %b lrck %b expected 2 1 0",
               waited, stb1, lrck1);
    end
    run_frame(1'b1, "div1_frame", 16'hD580, 16'h3F80, 64, 9'h0AB, 9'h17F, 1'b0);
    run_frame(1'b1, "div1_frame2", 16'hD580, 16'h3F80, 64, 9'h0AB, 9'h17F, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame_data();
    test_input_change();
    test_midpoint();
    test_mute();
    test_pattern();
    test_reset_mid_frame();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
